// File: rtl/dibit_pkg.sv
// Shared widths, types and slot-to-bit mapping for the dibit packer.
// DIBIT_PACKER_MSB_FIRST_EN selects MSB-first slot placement.
package dibit_pkg;

  localparam int DW     = 2;
  localparam int SLOTS  = 4;
  localparam int WW     = DW * SLOTS;
  localparam int SLOT_W = $clog2(SLOTS);

  typedef logic [DW-1:0]     slice_t;
  typedef logic [WW-1:0]     word_t;
  typedef logic [SLOT_W-1:0] slot_t;

  // Low bit of the field that slot k fills in a word of 'slots' slices of 'dw' bits.
  function automatic int slice_lo(input int k, input int dw, input int slots);
`ifdef DIBIT_PACKER_MSB_FIRST_EN
    return (slots - 1 - k) * dw;
`else
    return k * dw;
`endif
  endfunction

endpackage

// File: rtl/dibit_out_reg.sv
// One-entry valid/ready output register: load, hold, or drain-and-reload in one cycle.
module dibit_out_reg #(
  parameter int WW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [WW-1:0] data_i,
  input  logic          ready_i,
  output logic [WW-1:0] data_o,
  output logic          valid_o
);

  logic          valid_q, valid_d;
  logic [WW-1:0] data_q, data_d;

  // The producer only loads when the slot is free or draining this cycle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/dibit_packer.sv
// Packs a stream of DW-bit slices into WW-bit words with valid/ready on both sides.
// DIBIT_PACKER_MSB_FIRST_EN puts slot 0 in the top field instead of the bottom one.
module dibit_packer #(
  parameter int DW    = dibit_pkg::DW,
  parameter int SLOTS = dibit_pkg::SLOTS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DW-1:0]            in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     sync,
  output logic [DW*SLOTS-1:0]      out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(SLOTS)-1:0] slot
);

  localparam int WW  = DW * SLOTS;
  localparam int SW  = $clog2(SLOTS);
  localparam int LO0 = dibit_pkg::slice_lo(0, DW, SLOTS);
  localparam logic [SW-1:0] LAST = SW'(SLOTS - 1);

  logic [SW-1:0] slot_q, slot_d;
  logic [WW-1:0] asm_q, asm_d;
  logic [WW-1:0] ins;
  logic          at_last, accept, complete;

  assign at_last  = (slot_q == LAST);
  // Only the completing beat can stall, and only against a full, non-draining output.
  assign in_ready = !(at_last && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign complete = accept && !sync && at_last;

  // Assembly register with the incoming slice merged at the current slot.
  for (genvar k = 0; k < SLOTS; k++) begin : g_slot
    localparam int LO = dibit_pkg::slice_lo(k, DW, SLOTS);
    assign ins[LO +: DW] = (slot_q == SW'(k)) ? in_data : asm_q[LO +: DW];
  end

  always_comb begin
    slot_d = slot_q;
    asm_d  = asm_q;
    if (sync) begin
      slot_d = '0;
      asm_d  = '0;
      if (accept) begin
        asm_d[LO0 +: DW] = in_data;
        slot_d           = SW'(1);
      end
    end else if (accept) begin
      if (at_last) begin
        slot_d = '0;
        asm_d  = '0;
      end else begin
        slot_d = slot_q + 1'b1;
        asm_d  = ins;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
      asm_q  <= '0;
    end else begin
      slot_q <= slot_d;
      asm_q  <= asm_d;
    end
  end

  dibit_out_reg #(.WW(WW)) u_out (
    .clk     (clk),
    .rst     (rst),
    .load_i  (complete),
    .data_i  (ins),
    .ready_i (out_ready),
    .data_o  (out_data),
    .valid_o (out_valid)
  );

  assign slot = slot_q;

endmodule
